aes_key_expander: RTL and testbench
===================================

// Module: aes_key_expander
// PURPOSE
//  Iterative AES-128 key schedule. Loads a 128-bit cipher key and emits round keys 0..10 in order.
//  Emits one round key per handshake beat to the downstream round datapath.
//  Upstream of the byte S-box: drives four SubWord instances with RotWord(w3) and consumes their
//  outputs to build w[4i..4i+3]. Sits between the key input register and AddRoundKey.
// PARAMETERS
//  PIPE_SBOX  0  0: S-box path is combinational within the advance cycle; 1: S-box outputs are registered (+1 cycle per round)
//  NR         10 number of rounds; fixed at 10 for AES-128; any other value is a synthesis error
// PORTS
//  clk            in   1    single clock, rising edge
//  rst_n          in   1    synchronous, active-low reset
//  start          in   1    load keyIn and begin expansion; sampled only in IDLE
//  keyIn          in   128  cipher key; keyIn[127:96]=w0 ... keyIn[31:0]=w3; byte [127:120] is key byte 0
//  roundKey       out  128  current round key, same word/byte order as keyIn
//  roundIdx       out  4    index of roundKey, 0..10
//  roundKeyValid  out  1    roundKey/roundIdx are valid
//  roundKeyReady  in   1    consumer accepts the current key when valid&&ready
//  busy           out  1    high from the cycle after start is accepted until done
//  done           out  1    one-cycle pulse after round 10 is accepted
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE, roundKey=0, roundIdx=0, roundKeyValid=0, busy=0, done=0, rcon=8'h01.
//   - Reset mid-expansion aborts immediately; no partial keys are emitted afterwards.
//  States: IDLE, PRESENT, SUBST (used only when PIPE_SBOX=1), FINISH.
//  IDLE:
//   - If start=1, register keyIn into roundKey, set roundIdx=0, roundKeyValid=1, busy=1 -> PRESENT.
//   - Latency: key 0 is valid on the cycle after start is sampled.
//  PRESENT: roundKeyValid=1. roundKey/roundIdx are held stable while ready=0 (no change under back-pressure).
//   - Beat with roundIdx<10:
//     - PIPE_SBOX=0: the next round key loads on the same edge; valid stays high; roundIdx+1.
//       Back-to-back beats give one key per cycle.
//     - PIPE_SBOX=1: valid drops, S-box results are registered -> SUBST.
//       SUBST loads the next key and returns to PRESENT, so valid is low for exactly 1 cycle per round.
//   - Beat with roundIdx==10: valid=0 -> FINISH.
//  FINISH: done=1 for one cycle; busy=0 on the same cycle; -> IDLE.
//  start while busy is ignored and does not disturb the key sequence. start in the FINISH cycle is also ignored.
//  Next-key arithmetic (words w0..w3 of the current key):
//   - t  = SubWord4(RotWord(w3)) ^ {rcon,24'h0}
//   - RotWord({a,b,c,d}) = {b,c,d,a}; SubWord4 applies the byte S-box to each of the 4 bytes.
//   - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
//  rcon:
//   - Sequence 01,02,04,08,10,20,40,80,1B,36; the rcon used for round i is rcon[i-1].
//   - Update is an xtime shift: rcon<<1, reduced by 8'h1B when bit 7 was set. This gives 80 -> 1B -> 36.
//   - rcon advances only on a key-producing beat and is reset to 01 on each start.
//  roundIdx never exceeds 10 and never wraps. Outputs change only on clk edges.
// STRUCTURE
//  aes_pkg: typedef word_t [31:0]; RCON_INIT=8'h01; RCON_POLY=8'h1B; NR_AES128=10; state enum.
//  Sub-module aes_key_step: combinational next-key function. It takes the current key and rcon and
//   returns the next key, instantiating four SubWord byte S-boxes. The FSM, rcon register and optional
//   pipeline register live in aes_key_expander.
// TESTING (FIPS-197 App. A.1 key 2b7e151628aed2a6abf7158809cf4f3c)
//  1 start pulse, ready=1 always, PIPE_SBOX=0:
//    - key0=2b7e1516..09cf4f3c one cycle after start; key1=a0fafe1788542cb123a339392a6c7605.
//    - key10=d014f9a8c9ee2589e13f0cc8b6630ca6 with roundIdx=10 at start+11.
//    - done pulses at start+12.
//  2 back-pressure:
//    - hold ready=0 for 5 cycles at roundIdx=3 -> roundKey stays 3d80477d4716fe3e1e237e446d7a883b, valid=1.
//    - Releasing ready continues the sequence with key4 correct.
//  3 PIPE_SBOX=1, ready=1:
//    - valid alternates 1,0 per round; same 11 keys as test 1; done at start+22.
//  4 reset mid-expansion:
//    - drop rst_n at roundIdx=6 -> next cycle valid=0, busy=0, roundKey=0.
//    - A new start yields key0 again.
//  5 start pulsed while busy (at roundIdx=2) with a different keyIn -> the sequence is unchanged.
//    start in IDLE after done -> a new expansion of the new key.
//  6 all-zero key -> key1=62636363626363636263636362636363 and key10=b4ef5bcb3e92e21123e951cf6f8f188e.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and GF(2^8) helpers for the AES-128 key schedule
package aes_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, PRESENT, SUBST, FINISH} state_t;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;
  localparam int NR_AES128 = 10;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // Byte S-box: multiplicative inverse as x^254 (0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: combinational AES-128 next-round-key function
//   key     in  128  current round key, w0 in [127:96]
//   rcon    in  8    round constant for the key being produced
//   nextKey out 128  following round key, same word order
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] nextKey
);
  word_t w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
  assign {w0, w1, w2, w3} = key;
  assign rot = {w3[23:0], w3[31:24]};
  for (genvar g = 0; g < 4; g++) begin : gSubWord
    assign sub[8*g +: 8] = sbox(rot[8*g +: 8]);
  end
  assign t = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign nextKey = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule emitting round keys 0..10 over a valid/ready handshake
//   clk, rst_n       clock, synchronous active-low reset
//   start, keyIn     begin expansion of keyIn (sampled only when idle)
//   roundKey, roundIdx, roundKeyValid / roundKeyReady   round-key stream
//   busy, done       expansion in progress / one-cycle completion pulse
module aes_key_expander
  import aes_pkg::*;
#(
  parameter bit PIPE_SBOX = 1'b0,
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] keyIn,
  output logic [127:0] roundKey,
  output logic [3:0]   roundIdx,
  output logic         roundKeyValid,
  input  logic         roundKeyReady,
  output logic         busy,
  output logic         done
);
  if (NR != NR_AES128) begin : gBadNr
    $error("aes_key_expander supports only NR=10");
  end
  state_t state, stateNext;
  logic [127:0] stepKey, pipeKey, keyD, pipeD;
  logic [3:0] idxD;
  logic [7:0] rcon, rconD;
  aes_key_step uStep (.key(roundKey), .rcon(rcon), .nextKey(stepKey));
  always_comb begin
    stateNext = state;
    keyD = roundKey;
    idxD = roundIdx;
    rconD = rcon;
    pipeD = pipeKey;
    case (state)
      IDLE: if (start) begin
        stateNext = PRESENT;
        keyD = keyIn;
        idxD = '0;
        rconD = RCON_INIT;
      end
      PRESENT: if (roundKeyReady) begin
        if (roundIdx == 4'(NR)) stateNext = FINISH;
        else begin
          rconD = xtime(rcon);
          // Pipelined variant parks the next key for a cycle before presenting it.
          if (PIPE_SBOX) begin
            pipeD = stepKey;
            stateNext = SUBST;
          end else begin
            keyD = stepKey;
            idxD = roundIdx + 4'd1;
          end
        end
      end
      SUBST: begin
        keyD = pipeKey;
        idxD = roundIdx + 4'd1;
        stateNext = PRESENT;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      roundKey <= '0;
      roundIdx <= '0;
      rcon <= RCON_INIT;
      pipeKey <= '0;
    end else begin
      state <= stateNext;
      roundKey <= keyD;
      roundIdx <= idxD;
      rcon <= rconD;
      pipeKey <= pipeD;
    end
  end
  assign roundKeyValid = state == PRESENT;
  assign busy = state == PRESENT || state == SUBST;
  assign done = state == FINISH;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: self-checking bench for both S-box pipeline variants
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic startS[2];
  logic readyS[2];
  logic [127:0] keyInS[2];
  logic [127:0] rk[2];
  logic [3:0] idx[2];
  logic vld[2];
  logic busyS[2];
  logic doneS[2];
  int checks = 0;
  int errors = 0;
  logic [7:0] sboxTab[256];
  logic [127:0] modelKeys[11];
  logic [7:0] rconTab[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expander #(.PIPE_SBOX(1'b0), .NR(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(startS[0]), .keyIn(keyInS[0]), .roundKey(rk[0]),
    .roundIdx(idx[0]), .roundKeyValid(vld[0]), .roundKeyReady(readyS[0]), .busy(busyS[0]), .done(doneS[0]));
  aes_key_expander #(.PIPE_SBOX(1'b1), .NR(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startS[1]), .keyIn(keyInS[1]), .roundKey(rk[1]),
    .roundIdx(idx[1]), .roundKeyValid(vld[1]), .roundKeyReady(readyS[1]), .busy(busyS[1]), .done(doneS[1]));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    while (b != 0) begin
      if (b[0]) r ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1B : 8'h00);
      b >>= 1;
    end
    return r;
  endfunction

  task automatic buildSbox;
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sboxTab[x] = s;
    end
  endtask

  task automatic buildModel(input logic [127:0] key);
    logic [31:0] w[44];
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sboxTab[temp[31:24]], sboxTab[temp[23:16]], sboxTab[temp[15:8]], sboxTab[temp[7:0]]};
        temp ^= {rconTab[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) modelKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic startDut(input int d, input logic [127:0] key);
    keyInS[d] = key;
    startS[d] = 1'b1;
    tick;
    startS[d] = 1'b0;
  endtask

  task automatic waitDone(input int d);
    int n = 0;
    while (!doneS[d] && n < 60) begin
      tick;
      n++;
    end
    chk("doneSeen", 128'(doneS[d]), 128'd1);
    tick;
  endtask

  task automatic runExp(input int d, input logic [127:0] key, input bit randReady);
    int k = 0;
    int cyc = 0;
    buildModel(key);
    readyS[d] = 1'b1;
    startDut(d, key);
    while (k <= 10 && cyc < 200) begin
      readyS[d] = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vld[d]) begin
        chk("rndKey", rk[d], modelKeys[k]);
        chk("rndIdx", 128'(idx[d]), 128'(k));
        chk("rndBusy", 128'(busyS[d]), 128'd1);
        if (readyS[d]) k++;
      end
      tick;
      cyc++;
    end
    chk("rndComplete", 128'(k), 128'd11);
    chk("rndDone", 128'(doneS[d]), 128'd1);
    chk("rndDoneBusy", 128'(busyS[d]), 128'd0);
    readyS[d] = 1'b1;
    tick;
  endtask

  initial begin
    startS = '{1'b0, 1'b0};
    readyS = '{1'b1, 1'b1};
    keyInS = '{128'h0, 128'h0};
    buildSbox;
    rst_n = 1'b0;
    tick;
    tick;
    for (int d = 0; d < 2; d++) begin
      chk("rstKey", rk[d], 128'h0);
      chk("rstIdx", 128'(idx[d]), 128'h0);
      chk("rstValid", 128'(vld[d]), 128'h0);
      chk("rstBusy", 128'(busyS[d]), 128'h0);
      chk("rstDone", 128'(doneS[d]), 128'h0);
    end
    rst_n = 1'b1;
    tick;
    // FIPS-197 vector, one key per cycle
    buildModel(FIPS);
    startDut(0, FIPS);
    chk("fipsKey0", rk[0], FIPS);
    chk("fipsIdx0", 128'(idx[0]), 128'd0);
    chk("fipsValid0", 128'(vld[0]), 128'd1);
    chk("fipsBusy0", 128'(busyS[0]), 128'd1);
    tick;
    chk("fipsKey1", rk[0], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fipsIdx1", 128'(idx[0]), 128'd1);
    for (int i = 2; i <= 10; i++) begin
      tick;
      chk("fipsKeyN", rk[0], modelKeys[i]);
      chk("fipsIdxN", 128'(idx[0]), 128'(i));
    end
    chk("fipsKey10", rk[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick;
    chk("fipsDone", 128'(doneS[0]), 128'd1);
    chk("fipsDoneBusy", 128'(busyS[0]), 128'd0);
    chk("fipsDoneValid", 128'(vld[0]), 128'd0);
    tick;
    chk("fipsDoneDrop", 128'(doneS[0]), 128'd0);
    // back-pressure at roundIdx 3
    startDut(0, FIPS);
    repeat (3) tick;
    chk("bpIdx3", 128'(idx[0]), 128'd3);
    readyS[0] = 1'b0;
    repeat (5) begin
      tick;
      chk("bpHoldKey", rk[0], 128'h3d80477d4716fe3e1e237e446d7a883b);
      chk("bpHoldValid", 128'(vld[0]), 128'd1);
      chk("bpHoldIdx", 128'(idx[0]), 128'd3);
    end
    readyS[0] = 1'b1;
    tick;
    chk("bpKey4", rk[0], modelKeys[4]);
    chk("bpIdx4", 128'(idx[0]), 128'd4);
    waitDone(0);
    // pipelined S-box: valid alternates, done at start+22
    startDut(1, FIPS);
    for (int i = 0; i <= 10; i++) begin
      chk("pipeValid", 128'(vld[1]), 128'd1);
      chk("pipeKey", rk[1], modelKeys[i]);
      chk("pipeIdx", 128'(idx[1]), 128'(i));
      tick;
      if (i < 10) begin
        chk("pipeGap", 128'(vld[1]), 128'd0);
        chk("pipeGapBusy", 128'(busyS[1]), 128'd1);
        tick;
      end
    end
    chk("pipeDone", 128'(doneS[1]), 128'd1);
    chk("pipeDoneBusy", 128'(busyS[1]), 128'd0);
    tick;
    // reset mid-expansion
    begin
      logic [127:0] key = rand128();
      buildModel(key);
      startDut(0, key);
      repeat (6) tick;
      chk("midIdx6", 128'(idx[0]), 128'd6);
      chk("midKey6", rk[0], modelKeys[6]);
      rst_n = 1'b0;
      tick;
      chk("midRstValid", 128'(vld[0]), 128'd0);
      chk("midRstBusy", 128'(busyS[0]), 128'd0);
      chk("midRstKey", rk[0], 128'h0);
      chk("midRstIdx", 128'(idx[0]), 128'd0);
      rst_n = 1'b1;
      repeat (3) begin
        tick;
        chk("midQuiet", 128'(vld[0]), 128'd0);
      end
      startDut(0, key);
      chk("midRestartKey0", rk[0], modelKeys[0]);
      chk("midRestartValid", 128'(vld[0]), 128'd1);
      waitDone(0);
    end
    // start while busy is ignored
    begin
      logic [127:0] a = rand128();
      logic [127:0] b = rand128();
      buildModel(a);
      startDut(0, a);
      tick;
      tick;
      chk("busyIdx2", 128'(idx[0]), 128'd2);
      keyInS[0] = b;
      startS[0] = 1'b1;
      tick;
      startS[0] = 1'b0;
      chk("busyKey3", rk[0], modelKeys[3]);
      for (int i = 4; i <= 10; i++) begin
        tick;
        chk("busyKeyN", rk[0], modelKeys[i]);
      end
      tick;
      chk("busyDone", 128'(doneS[0]), 128'd1);
      startS[0] = 1'b1;
      tick;
      startS[0] = 1'b0;
      chk("finishStartIgnored", 128'(vld[0]), 128'd0);
      runExp(0, b, 1'b0);
    end
    // all-zero key
    startDut(0, 128'h0);
    tick;
    chk("zeroKey1", rk[0], 128'h62636363626363636263636362636363);
    repeat (9) tick;
    chk("zeroKey10", rk[0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zeroIdx10", 128'(idx[0]), 128'd10);
    tick;
    chk("zeroDone", 128'(doneS[0]), 128'd1);
    tick;
    // random keys with random back-pressure on both variants
    repeat (4) begin
      runExp(0, rand128(), 1'b1);
      runExp(1, rand128(), 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
